ahb_lite_sram_slave: RTL

- Parametrised AHB-lite SRAM slave. It generalises the current fixed-width 32-bit zero-wait memory DUT exercised by the AHB testbench.
- Adds configurable data width, depth and wait states, byte/halfword/word (and doubleword) sizes, and the two-cycle ERROR response.
- Sits behind the AHB-lite decoder/mux as a leaf slave. It is the DUT for the next-generation env (driver/monitor/ref model/scoreboard).

---
 rtl/ahb_lite_pkg.sv | 48 ++++
 rtl/ahb_sram_array.sv | 30 +++
 rtl/ahb_lite_sram_slave.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, slave FSM states and the byte-strobe helper.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    ERR1,
    ERR2
  } slave_state_e;

  // Little-endian lane strobe for a naturally aligned access; bits above
  // data_bytes are forced to zero so the caller can take the low slice.
  function automatic logic [7:0] byte_en(input logic [2:0] addr_lo,
                                         input logic [2:0] size,
                                         input int         data_bytes);
    logic [7:0] base;
    logic [7:0] lane_mask;
    logic [2:0] off;
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0F;
      default:    base = 8'hFF;
    endcase
    off       = addr_lo & 3'(data_bytes - 1);
    lane_mask = (data_bytes >= 8) ? 8'hFF : 8'h0F;
    return (base << off) & lane_mask;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// MEM_DEPTH x DATA_WIDTH storage: byte-strobed synchronous write, combinational read.
module ahb_sram_array
  import ahb_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_addr,
  input  logic [DATA_WIDTH/8-1:0]      i_wstrb,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM leaf slave with configurable width, depth and wait states.
// Errors (range, alignment, oversize) take the two-cycle ERROR response.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int         NB       = DATA_WIDTH / 8;
  localparam int         ADDR_LSB = $clog2(NB);
  localparam int         AW       = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);
  localparam logic [3:0] WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e          r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [AW-1:0]         r_word;
  logic [NB-1:0]         r_strb;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic                  r_hreadyout;
  logic                  r_hresp;

  logic                  w_accept;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic [2:0]            w_align_mask;
  logic [7:0]            w_strb_full;
  logic [NB-1:0]         w_strb;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [DATA_WIDTH-1:0] w_lane_mask;
  logic [DATA_WIDTH-1:0] w_rd_lanes;

  assign w_accept   = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign w_word_idx = haddr >> ADDR_LSB;

  always_comb begin
    w_align_mask = 3'b111;
    case (hsize)
      HSIZE_BYTE: w_align_mask = 3'b000;
      HSIZE_HALF: w_align_mask = 3'b001;
      HSIZE_WORD: w_align_mask = 3'b011;
      default:    w_align_mask = 3'b111;
    endcase
  end

  assign w_err = (w_word_idx >= ADDR_WIDTH'(MEM_DEPTH))
               | (|(haddr[2:0] & w_align_mask))
               | (hsize > MAX_SIZE);

  assign w_strb_full = byte_en(haddr[2:0], hsize, NB);
  assign w_strb      = w_strb_full[NB-1:0];

  // Gated by reset so a write caught by reset in its final cycle is dropped.
  assign w_we = (r_state == XFER) & r_write & ~hreset;

  always_comb begin
    w_lane_mask = '0;
    for (int b = 0; b < NB; b++) w_lane_mask[b*8 +: 8] = {8{r_strb[b]}};
  end

  assign w_rd_lanes = w_mem_rdata & w_lane_mask;

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (hclk),
    .i_we    (w_we),
    .i_addr  (r_word),
    .i_wstrb (r_strb),
    .i_wdata (hwdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_word      <= '0;
      r_strb      <= '0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      if ((r_state == XFER) && !r_write) r_hrdata <= w_rd_lanes;
      case (r_state)
        IDLE, XFER, ERR2: begin
          if (w_accept) begin
            r_write <= hwrite;
            r_word  <= w_word_idx[AW-1:0];
            r_strb  <= w_strb;
            if (w_err) begin
              r_state     <= ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              r_state     <= WAIT;
              r_cnt       <= WS_LOAD;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end else begin
              r_state     <= XFER;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
            end
          end else begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= XFER;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ERR1: begin
          r_state     <= ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Read data is live during the completing cycle so a write committed the
  // cycle before is visible without a bypass path.
  assign hrdata    = ((r_state == XFER) && !r_write) ? w_rd_lanes : r_hrdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule
